// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
// master = producer/consumer side, slave = controller side.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared 1-bit full-add slice swept LSB first
// over WIDTH cycles, with valid/ready handshakes on operands and result.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave io
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be in 2..32");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  // Shared adder slice: two half-adder stages, carries merged by OR
  logic s1, c1, s2, c2, carry_nxt;
  assign s1        = a_sh_q[0] ^ b_sh_q[0];
  assign c1        = a_sh_q[0] & b_sh_q[0];
  assign s2        = s1 ^ carry_q;
  assign c2        = s1 & carry_q;
  assign carry_nxt = c1 | c2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (io.in_valid) begin
          state_d = ST_RUN;
          a_sh_d  = io.a;
          b_sh_d  = io.b;
          carry_d = io.cin;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      ST_RUN: begin
        sum_d   = {s2, sum_q[WIDTH-1:1]};
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        // Last slice: latch carry-out; counter holds so it never wraps
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          cout_d  = carry_nxt;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (io.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake flags registered from the next state
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.busy      = busy_q;
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl against an arithmetic
// a+b+cin reference, with WIDTH=8 main instance plus WIDTH=2/32 instances.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  logic [63:0] last_res;

  serial_add_ctrl_if #(.WIDTH(W))  sa();
  serial_add_ctrl_if #(.WIDTH(2))  sa2();
  serial_add_ctrl_if #(.WIDTH(32)) sa32();

  serial_add_ctrl #(.WIDTH(W))  u_dut   (.clk(clk), .rst_n(rst_n), .io(sa));
  serial_add_ctrl #(.WIDTH(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .io(sa2));
  serial_add_ctrl #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .io(sa32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the WIDTH=8 instance; stall = cycles of out_ready=0 once result is up
  task automatic do_txn(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input int stall, input bit noise);
    logic [63:0] exp;
    int          cyc;
    bit          seen;
    exp = 64'(ta) + 64'(tb) + 64'(tc);
    check_eq("idle_in_ready", 64'(sa.in_ready), 64'd1);
    sa.in_valid  = 1'b1;
    sa.a         = ta;
    sa.b         = tb;
    sa.cin       = tc;
    sa.out_ready = (stall == 0);
    tick();
    sa.in_valid = 1'b0;
    check_eq("accept_busy", 64'(sa.busy), 64'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 4 * W) begin
      if (noise) begin
        sa.a        = 8'($urandom);
        sa.b        = 8'($urandom);
        sa.cin      = 1'($urandom);
        sa.in_valid = 1'($urandom);
      end
      tick();
      cyc++;
      seen = sa.out_valid;
      if (!seen) check_eq("run_in_ready", 64'(sa.in_ready), 64'd0);
    end
    check_eq("latency", 64'(cyc), 64'(W));
    check_eq("sum", 64'(sa.sum), exp & 64'hFF);
    check_eq("cout", 64'(sa.cout), 64'(exp[8]));
    for (int s = 0; s < stall; s++) begin
      if (noise) begin
        sa.a        = 8'($urandom);
        sa.b        = 8'($urandom);
        sa.in_valid = 1'($urandom);
      end
      tick();
      check_eq("stall_valid", 64'(sa.out_valid), 64'd1);
      check_eq("stall_in_ready", 64'(sa.in_ready), 64'd0);
      check_eq("stall_sum", 64'(sa.sum), exp & 64'hFF);
      check_eq("stall_cout", 64'(sa.cout), 64'(exp[8]));
    end
    sa.out_ready = 1'b1;
    tick();
    sa.in_valid = 1'b0;
    check_eq("post_valid", 64'(sa.out_valid), 64'd0);
    check_eq("post_in_ready", 64'(sa.in_ready), 64'd1);
    check_eq("post_busy", 64'(sa.busy), 64'd0);
    check_eq("post_sum_hold", 64'(sa.sum), exp & 64'hFF);
    last_res = exp;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_eq("idle_valid", 64'(sa.out_valid), 64'd0);
      check_eq("idle_sum_hold", 64'(sa.sum), last_res & 64'hFF);
      check_eq("idle_cout_hold", 64'(sa.cout), 64'(last_res[8]));
    end
  endtask

  task automatic txn_w2(input logic [1:0] ta, input logic [1:0] tb, input logic tc);
    logic [63:0] exp;
    int          cyc;
    exp = 64'(ta) + 64'(tb) + 64'(tc);
    sa2.in_valid = 1'b1; sa2.a = ta; sa2.b = tb; sa2.cin = tc; sa2.out_ready = 1'b1;
    tick();
    sa2.in_valid = 1'b0;
    cyc = 0;
    while (!sa2.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq("w2_latency", 64'(cyc), 64'd2);
    check_eq("w2_sum", 64'(sa2.sum), exp & 64'h3);
    check_eq("w2_cout", 64'(sa2.cout), 64'(exp[2]));
    tick();
    check_eq("w2_in_ready", 64'(sa2.in_ready), 64'd1);
  endtask

  task automatic txn_w32(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
    logic [63:0] exp;
    int          cyc;
    exp = 64'(ta) + 64'(tb) + 64'(tc);
    sa32.in_valid = 1'b1; sa32.a = ta; sa32.b = tb; sa32.cin = tc; sa32.out_ready = 1'b1;
    tick();
    sa32.in_valid = 1'b0;
    cyc = 0;
    while (!sa32.out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check_eq("w32_latency", 64'(cyc), 64'd32);
    check_eq("w32_sum", 64'(sa32.sum), exp & 64'hFFFF_FFFF);
    check_eq("w32_cout", 64'(sa32.cout), 64'(exp[32]));
    tick();
    check_eq("w32_in_ready", 64'(sa32.in_ready), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk    = 0;
    n_err    = 0;
    last_res = '0;
    rst_n = 1'b0;
    sa.in_valid = 1'b1; sa.a = 8'h77; sa.b = 8'h11; sa.cin = 1'b1; sa.out_ready = 1'b0;
    sa2.in_valid = 1'b0; sa2.a = '0; sa2.b = '0; sa2.cin = 1'b0; sa2.out_ready = 1'b0;
    sa32.in_valid = 1'b0; sa32.a = '0; sa32.b = '0; sa32.cin = 1'b0; sa32.out_ready = 1'b0;

    // Reset held with in_valid high: reset wins every edge
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_in_ready", 64'(sa.in_ready), 64'd1);
      check_eq("rst_out_valid", 64'(sa.out_valid), 64'd0);
      check_eq("rst_busy", 64'(sa.busy), 64'd0);
      check_eq("rst_sum", 64'(sa.sum), 64'd0);
      check_eq("rst_cout", 64'(sa.cout), 64'd0);
    end
    rst_n = 1'b1;
    sa.in_valid = 1'b0;
    idle_cycles(2);

    do_txn(8'h35, 8'h4A, 1'b0, 0, 1'b0);
    do_txn(8'hFF, 8'h01, 1'b1, 0, 1'b0);
    do_txn(8'h80, 8'h80, 1'b0, 0, 1'b0);
    idle_cycles(3);
    do_txn(8'h12, 8'h34, 1'b0, 5, 1'b1);

    // Abort mid-run: reset at the 4th RUN edge
    sa.in_valid = 1'b1; sa.a = 8'hAA; sa.b = 8'h55; sa.cin = 1'b0; sa.out_ready = 1'b1;
    tick();
    sa.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("abort_in_ready", 64'(sa.in_ready), 64'd1);
    check_eq("abort_out_valid", 64'(sa.out_valid), 64'd0);
    check_eq("abort_busy", 64'(sa.busy), 64'd0);
    check_eq("abort_sum", 64'(sa.sum), 64'd0);
    check_eq("abort_cout", 64'(sa.cout), 64'd0);
    last_res = '0;
    idle_cycles(W + 2);
    do_txn(8'h01, 8'h02, 1'b0, 0, 1'b0);

    // Back-to-back randomized traffic with random stalls and idle gaps
    for (int t = 0; t < 1000; t++) begin
      do_txn(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
      if ($urandom_range(0, 7) == 0) idle_cycles(int'($urandom_range(1, 2)));
    end

    txn_w2(2'b11, 2'b11, 1'b1);
    txn_w2(2'b11, 2'b11, 1'b0);
    txn_w32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    txn_w32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Sequences one shared 1-bit adder slice (two half-adder stages plus OR for carry) over WIDTH cycles, LSB first.
- Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Sits between an operand producer and a result consumer; trades latency for area against a parallel ripple adder.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  controller can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  A+B+cin, low WIDTH bits
cout  output  1  carry-out of bit WIDTH-1
busy  output  1  high in RUN or DONE

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low.
  - All state updates on the rising edge of clk.
  - rst_n=0 at an edge forces: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, bit counter=0, internal carry=0, operand shift registers=0.
- State machine (IDLE, RUN, DONE):
  - IDLE: in_ready=1, out_valid=0, busy=0.
  - IDLE→RUN: in_valid=1 at an edge. Latch a and b into shift registers, carry<=cin, counter<=0, sum<=0.
  - IDLE without in_valid: stay IDLE; sum and cout hold their last values.
  - RUN: in_ready=0, busy=1, out_valid=0.
- Per-edge operation in RUN:
  - s1=a_sh[0]^b_sh[0]; c1=a_sh[0]&b_sh[0].
  - s2=s1^carry; c2=s1&carry.
  - sum shifts right with s2 entering the MSB; a_sh and b_sh shift right (zero fill).
  - carry<=c1|c2; counter<=counter+1.
- RUN→DONE: on the edge where counter==WIDTH-1 (the WIDTH-th RUN edge).
  - On that same edge, cout<=c1|c2 and the final sum bit enters.
  - After WIDTH shifts, sum[i] = bit i of the result.
- DONE: out_valid=1, busy=1, in_ready=0. sum and cout are stable and must not change while out_valid=1.
- DONE→IDLE: out_valid&out_ready at an edge. out_valid falls and in_ready rises the following cycle. sum and cout retain the result until the next acceptance.
- Latency:
  - Operands accepted at edge k → out_valid=1 from edge k+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles with out_ready held high.
- Boundary conditions:
  - out_ready high before out_valid: no effect.
  - in_valid while not in IDLE: ignored, no operand capture; the producer must hold its data until in_ready.
  - Changes on a/b/cin during RUN or DONE: no effect.
  - Overflow: sum wraps modulo 2^WIDTH; cout=1 exactly when a+b+cin ≥ 2^WIDTH.
  - Reset asserted mid-RUN or in DONE: operation aborted, no result ever presented, all outputs return to reset values at that edge.
  - rst_n and in_valid both active at the same edge: reset wins.
- Counter width: clog2(WIDTH) bits; it never wraps because RUN exits at WIDTH-1.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → in_ready=1, out_valid=0, busy=0, sum=0, cout=0 throughout; no transaction starts.
- Basic add, WIDTH=8: a=0x35, b=0x4A, cin=0 accepted at edge k, out_ready=1 → out_valid rises at edge k+8 for 1 cycle; sum=0x7F, cout=0; in_ready=1 again at edge k+9.
- Overflow with carry-in: a=0xFF, b=0x01, cin=1 → sum=0x01, cout=1. Then a=0x80, b=0x80, cin=0 → sum=0x00, cout=1.
- Backpressure: a=0x12, b=0x34, out_ready=0 for 5 cycles after out_valid; toggle a/b/in_valid meanwhile → sum stays 0x46, in_ready stays 0; transfer completes on the first edge with out_ready=1.
- Abort: accept a=0xAA, b=0x55, pull rst_n=0 at the 4th RUN edge → next cycle IDLE with all outputs at reset values. A following a=0x01, b=0x02 → sum=0x03 with correct 8-cycle latency.
- Random: 1000 back-to-back transactions with random a/b/cin and random out_ready stalls, compared to a reference model of a+b+cin; plus WIDTH=2 and WIDTH=32 builds with all-ones operands.
